// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream and instruction memory write port bundle
interface imem_loader_if;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   // master: host byte source plus instruction memory; slave: the loader
   modport master (
      output in_byte, in_valid,
      input  in_ready,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_byte, in_valid,
      output in_ready,
      output mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte stream to instruction memory loader holding the CPU while loading
// Optional CHECKSUM_EN: trailing XOR checksum byte checked before DONE.
module imem_loader #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   imem_loader_if.slave       bus,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [15:0]        words_loaded
);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;
`endif

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t      state, state_n;
   logic [15:0] len;
   logic [1:0]  byte_idx;
   logic [31:0] wdata;
   logic        in_ready_c;
   logic        mem_we_c;
   logic        xfer;
   logic [15:0] new_len;
   logic        len_bad;
   logic        session_start;
`ifdef CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign xfer          = bus.in_valid && in_ready_c;
   assign new_len       = {bus.in_byte, len[7:0]};
   assign len_bad       = (new_len == 16'd0) || ({1'b0, new_len} > MAX_WORDS);
   assign session_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

   assign bus.in_ready  = in_ready_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_wdata = wdata;
   // Address follows the word count so it reads BASE_ADDR in reset and at session start
   assign bus.mem_addr  = BASE_ADDR + {14'd0, words_loaded, 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      in_ready_c = 1'b0;
      mem_we_c   = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready_c = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer) state_n = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready_c = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer) state_n = len_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            in_ready_c = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer && byte_idx == 2'd3) state_n = S_WRITE;
         end
         S_WRITE: begin
            mem_we_c = 1'b1;
            cpu_hold = 1'b1;
            if (words_loaded + 16'd1 == len) begin
`ifdef CHECKSUM_EN
               state_n = S_CHK;
`else
               state_n = S_DONE;
`endif
            end else begin
               state_n = S_DATA;
            end
         end
`ifdef CHECKSUM_EN
         S_CHK: begin
            in_ready_c = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer) state_n = (bus.in_byte == csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            done = 1'b1;
            if (start) state_n = S_LEN_LO;
         end
         S_ERR: begin
            error    = 1'b1;
            cpu_hold = 1'b1;
            if (start) state_n = S_LEN_LO;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len          <= 16'd0;
         byte_idx     <= 2'd0;
         wdata        <= 32'd0;
         words_loaded <= 16'd0;
`ifdef CHECKSUM_EN
         csum         <= 8'd0;
`endif
      end else begin
         if (session_start) begin
            words_loaded <= 16'd0;
`ifdef CHECKSUM_EN
            csum         <= 8'd0;
`endif
         end
         case (state)
            S_LEN_LO: if (xfer) len[7:0] <= bus.in_byte;
            S_LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= bus.in_byte;
                  byte_idx  <= 2'd0;
               end
            end
            S_DATA: begin
               // Every lane is overwritten once per word, so no clear between words
               if (xfer) begin
                  wdata[8*byte_idx +: 8] <= bus.in_byte;
                  byte_idx               <= byte_idx + 2'd1;
`ifdef CHECKSUM_EN
                  csum                   <= csum ^ bus.in_byte;
`endif
               end
            end
            S_WRITE: words_loaded <= words_loaded + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic        wr_ready[$];
   logic [31:0] img[4];

   imem_loader_if bus();

   imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         wr_ready.push_back(bus.in_ready);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_ready.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_image(input logic [15:0] len, input int gap);
      logic [7:0] cs;
      cs = 8'd0;
      send_byte(len[7:0], gap);
      send_byte(len[15:8], gap);
      for (int w = 0; w < int'(len); w++) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(img[w][8*k +: 8], gap);
            cs = cs ^ img[w][8*k +: 8];
         end
      end
`ifdef CHECKSUM_EN
      send_byte(cs, gap);
`endif
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done || error) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("end_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bus.in_byte  = 8'h00;
      bus.in_valid = 1'b0;
      #12;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_words", words_loaded, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // single word load
      clear_log();
      pulse_start();
      check("t1_hold_loading", cpu_hold, 1);
      check("t1_ready_len_lo", bus.in_ready, 1);
      img[0] = 32'h0000_0013;
      send_image(16'd1, 0);
      wait_end();
      check("t1_nwrites", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check("t1_addr", wr_addr[0], 32'h0000_0000);
         check("t1_data", wr_data[0], 32'h0000_0013);
      end
      check("t1_done", done, 1);
      check("t1_hold", cpu_hold, 0);
      check("t1_words", words_loaded, 1);
      check("t1_ready_done", bus.in_ready, 0);

      // three words with gapped valid
      clear_log();
      pulse_start();
      img[0] = 32'h0050_0093;
      img[1] = 32'h0010_0113;
      img[2] = 32'h0020_81B3;
      send_image(16'd3, 1);
      wait_end();
      check("t2_nwrites", wr_addr.size(), 3);
      for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
         check("t2_addr", wr_addr[i], 32'(4 * i));
         check("t2_data", wr_data[i], img[i]);
         check("t2_ready_in_write", wr_ready[i], 0);
      end
      check("t2_done", done, 1);
      check("t2_words", words_loaded, 3);

      // zero length and oversize length
      clear_log();
      pulse_start();
      check("t3_words_cleared", words_loaded, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("t3_err_zero", error, 1);
      check("t3_hold_err", cpu_hold, 1);
      check("t3_done_err", done, 0);
      check("t3_ready_err", bus.in_ready, 0);
      pulse_start();
      check("t3_err_cleared", error, 0);
      check("t3_ready_len_lo", bus.in_ready, 1);
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("t3_err_257", error, 1);
      check("t3_nwrites", wr_addr.size(), 0);

      // reset mid-session
      clear_log();
      pulse_start();
      img[0] = 32'h1122_3344;
      img[1] = 32'h5566_7788;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
      send_byte(8'h88, 0);
      send_byte(8'h77, 0);
      check("t4_words_before", words_loaded, 1);
      #2 reset = 1'b0;
      #1;
      check("t4_hold_async", cpu_hold, 0);
      check("t4_ready_async", bus.in_ready, 0);
      check("t4_words_async", words_loaded, 0);
      check("t4_addr_async", bus.mem_addr, 32'h0);
      check("t4_wdata_async", bus.mem_wdata, 32'h0);
      check("t4_error_async", error, 0);
      check("t4_nwrites", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) check("t4_data", wr_data[0], 32'h1122_3344);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // start ignored in DATA, then start from DONE
      clear_log();
      pulse_start();
      img[0] = 32'hDEAD_BEEF;
      img[1] = 32'h0BAD_F00D;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      pulse_start();
      check("t5_hold_after_start", cpu_hold, 1);
      send_byte(8'hAD, 0);
      send_byte(8'hDE, 0);
      for (int k = 0; k < 4; k++) send_byte(img[1][8*k +: 8], 0);
`ifdef CHECKSUM_EN
      send_byte(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE ^ 8'h0D ^ 8'hF0 ^ 8'hAD ^ 8'h0B, 0);
`endif
      wait_end();
      check("t5_done", done, 1);
      check("t5_words", words_loaded, 2);
      check("t5_nwrites", wr_addr.size(), 2);
      if (wr_addr.size() >= 2) begin
         check("t5_data0", wr_data[0], 32'hDEAD_BEEF);
         check("t5_addr1", wr_addr[1], 32'h0000_0004);
         check("t5_data1", wr_data[1], 32'h0BAD_F00D);
      end
      pulse_start();
      check("t5_restart_words", words_loaded, 0);
      check("t5_restart_done", done, 0);
      check("t5_restart_addr", bus.mem_addr, 32'h0);

`ifdef CHECKSUM_EN
      // finish the open session, then checksum good and bad
      img[0] = 32'h0000_0013;
      send_image(16'd1, 0);
      wait_end();
      check("c1_done", done, 1);
      clear_log();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h12, 0);
      wait_end();
      check("c2_error", error, 1);
      check("c2_done", done, 0);
      check("c2_nwrites", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) check("c2_addr", wr_addr[0], 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program writer for the instruction memory that the PC/fetch path reads.
- Accepts a byte stream with a valid/ready handshake, assembles little-endian 32-bit instructions and issues single-cycle word writes into instruction memory.
- Holds the CPU (cpu_hold) while loading, so fetch never reads a half-written program.
- Sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
- ADDR_W, 8: word-address width of instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000: byte address where the first word is written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session from IDLE, DONE or ERR.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  32  byte address of the write.
- mem_wdata  output  32  assembled instruction.
- cpu_hold  output  1  CPU must stall/hold the PC while high.
- done  output  1  load completed successfully (level).
- error  output  1  load aborted (level, sticky).
- words_loaded  output  16  count of words written this session.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. in_ready, mem_we, cpu_hold, done and error are 0. mem_addr=BASE_ADDR; mem_wdata, words_loaded and the internal byte index are 0.
- A byte transfers only on a clk edge with in_valid && in_ready. in_ready depends only on state, never on in_valid.
- States and transitions:
  - IDLE: in_ready=0, cpu_hold=0. start -> LEN_LO; clears done, error and words_loaded.
  - LEN_LO: in_ready=1, cpu_hold=1. Transferred byte -> len[7:0]; go to LEN_HI.
  - LEN_HI: in_ready=1, cpu_hold=1. Transferred byte -> len[15:8]. If len==0 or len>2^ADDR_W, go to ERR; otherwise go to DATA with byte index 0.
  - DATA: in_ready=1, cpu_hold=1. Byte k (k=0..3) is placed in mem_wdata[8k+7:8k]. On the 4th transfer, go to WRITE.
  - WRITE: in_ready=0, mem_we=1 for exactly this cycle, mem_addr=BASE_ADDR+4*words_loaded, mem_wdata stable. Next edge: words_loaded+1. If the new count==len, go to DONE (or CHK when CHECKSUM_EN is defined); otherwise go to DATA.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> LEN_LO (new session).
  - ERR: error=1, cpu_hold=1 (CPU stays held on a bad image), in_ready=0. Only start or reset leaves ERR; start -> LEN_LO.
- Load latency per word: 4 accepted bytes plus 1 WRITE cycle. Minimum session is 2 + 5*len cycles.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHK.
- in_valid held low stalls indefinitely in the current state; there is no timeout.
- mem_addr arithmetic is 32-bit with no wrap. The len bound keeps the highest address at BASE_ADDR+4*(2^ADDR_W-1).
- Reset asserted mid-session aborts immediately. Memory contents already written are not cleared; cpu_hold drops to 0.
- mem_we never asserts outside WRITE.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - The stream carries one extra byte after the last data byte, in state CHK (in_ready=1, cpu_hold=1).
  - Checksum = XOR of every data byte (length bytes excluded).
  - Match -> DONE; mismatch -> ERR. Words already written stay written.
- Undefined: state CHK does not exist; after the last WRITE the loader goes straight to DONE, and no extra byte is consumed.

Test Plan:
- Reset, then start, stream 01 00 13 00 00 00 -> one mem_we pulse with mem_addr=0x0000_0000 and mem_wdata=0x0000_0013; then done=1, cpu_hold=0, words_loaded=1.
- len=3, words 0x00500093, 0x00100113, 0x002081B3, in_valid toggling 1/0 every cycle -> writes at 0x0, 0x4, 0x8 with those values; in_ready=0 in each WRITE cycle; no byte lost or duplicated.
- Length bytes 00 00 -> ERR: error=1, cpu_hold=1, no mem_we. Length 01 01 (257) with ADDR_W=8 -> ERR. Then start -> LEN_LO with error cleared.
- len=2, reset pulled low after 6 data bytes -> all outputs return to reset values asynchronously (before the next clk edge); exactly one mem_we occurred.
- start pulsed during DATA -> ignored, session completes normally. start in DONE -> new session, words_loaded restarts at 0.
- CHECKSUM_EN: len=1, data 13 00 00 00, checksum 13 -> done=1. Checksum 12 -> error=1 after one write at 0x0.
